// File: rtl/square_shift_add_pkg.sv
// Shared constants and types for the shift-add squarer.
// Q-format constants match the layernorm sqrt unit: root in Q2.10, square in Q4.20.
// Config macro: SQUARE_RADIX4_EN selects 2 multiplier bits per step (default 1).
package square_shift_add_pkg;

  localparam int unsigned FRAC_IN_DEF    = 10;
  localparam int unsigned RADICAND_FRAC  = 2 * FRAC_IN_DEF;
  localparam int unsigned ROOT_WIDTH_DEF = 12;
  localparam int unsigned OUT_WIDTH_DEF  = 24;

`ifdef SQUARE_RADIX4_EN
  localparam int unsigned BITS_PER_STEP = 2;
`else
  localparam int unsigned BITS_PER_STEP = 1;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } sq_state_e;

  // Number of accumulate steps for a given root width.
  function automatic int unsigned num_steps(input int unsigned root_width);
    return root_width / BITS_PER_STEP;
  endfunction

endpackage

// File: rtl/square_pp_sel.sv
// Partial-product select: returns 0, 1x, 2x or 3x of mcand for a 2-bit selector.
// In radix-2 builds the upper select bit is tied low, so this reduces to an AND gate.
// Ports:
//   mcand  in   WIDTH    multiplicand
//   sel    in   2        multiplier digit
//   pp     out  WIDTH+2  selected partial product
module square_pp_sel #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [1:0]       sel,
  output logic [WIDTH+1:0] pp
);

  always_comb begin
    pp = '0;
    case (sel)
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, mcand};
      2'b10:   pp = {1'b0, mcand, 1'b0};
      default: pp = {2'b00, mcand} + {1'b0, mcand, 1'b0};
    endcase
  end

endmodule

// File: rtl/square_shift_add.sv
// Iterative shift-add squarer (inverse of the layernorm sqrt unit).
// Unsigned root in Q(ROOT_WIDTH-FRAC).FRAC in, root^2 with 2*FRAC fraction bits out.
// Fixed latency: valid_out rises num_steps+1 edges after accept, for every operand.
// Config macro: SQUARE_RADIX4_EN (radix-4 steps; ROOT_WIDTH must then be even).
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   root_in, valid_in        operand and its valid
//   in_ready                 high in IDLE only
//   square_out, overflow_out result (saturated when OUT_WIDTH < 2*ROOT_WIDTH)
//   valid_out, out_ready     result handshake
module square_shift_add
  import square_shift_add_pkg::*;
#(
  parameter int unsigned ROOT_WIDTH = ROOT_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROOT_WIDTH-1:0] root_in,
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  square_out,
  output logic                  overflow_out,
  output logic                  valid_out,
  input  logic                  out_ready
);

  localparam int unsigned AccW   = 2 * ROOT_WIDTH;
  localparam int unsigned NSteps = num_steps(ROOT_WIDTH);
  localparam int unsigned CntW   = $clog2(NSteps + 1);

  sq_state_e state_q, state_d;

  logic [ROOT_WIDTH-1:0] mcand_q, mcand_d;
  logic [ROOT_WIDTH-1:0] mplier_q, mplier_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  square_q, square_d;
  logic                  overflow_q, overflow_d;

  logic                  accept;
  logic                  calc_last;
  logic [1:0]            pp_sel;
  logic [ROOT_WIDTH+1:0] pp;
  logic [CntW:0]         shamt;
  logic [AccW-1:0]       pp_shifted;
  logic [OUT_WIDTH-1:0]  sat_square;
  logic                  sat_overflow;

  assign accept = valid_in & in_ready;
  // All partial products are in acc once cnt reaches NSteps; that cycle registers the result.
  assign calc_last = (cnt_q == CntW'(NSteps));

`ifdef SQUARE_RADIX4_EN
  assign pp_sel = mplier_q[1:0];
  assign shamt  = {cnt_q, 1'b0};
`else
  assign pp_sel = {1'b0, mplier_q[0]};
  assign shamt  = {1'b0, cnt_q};
`endif

  square_pp_sel #(
    .WIDTH(ROOT_WIDTH)
  ) u_pp_sel (
    .mcand(mcand_q),
    .sel  (pp_sel),
    .pp   (pp)
  );

  assign pp_shifted = AccW'(pp) << shamt;

  // Output formatting: pass-through when wide enough, otherwise saturate.
  if (OUT_WIDTH >= AccW) begin : g_no_sat
    assign sat_square   = OUT_WIDTH'(acc_q);
    assign sat_overflow = 1'b0;
  end else begin : g_sat
    assign sat_overflow = |acc_q[AccW-1:OUT_WIDTH];
    assign sat_square   = sat_overflow ? '1 : acc_q[OUT_WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (calc_last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    valid_out = (state_q == StDone);
  end

  // Datapath next state.
  always_comb begin
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    square_d   = square_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          mcand_d  = root_in;
          mplier_d = root_in;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        if (calc_last) begin
          square_d   = sat_square;
          overflow_d = sat_overflow;
        end else begin
          acc_d    = acc_q + pp_shifted;
          mplier_d = mplier_q >> BITS_PER_STEP;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      square_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      square_q   <= square_d;
      overflow_q <= overflow_d;
    end
  end

  assign square_out   = square_q;
  assign overflow_out = overflow_q;

endmodule
